dual_port_ram_sync: RTL and testbench

Parametrised synchronous true dual-port RAM, the writable, clocked successor to the team's fixed 16x8 dual-port lookup ROM. Two independent read/write ports share one storage array. Reads are registered with a valid strobe, and write-write collisions are arbitrated and flagged. A built-in clear sequencer zero-fills the array after every reset, so contents are always known. The block serves as shared scratch/coefficient memory between two datapath engines on the same clock.

---
 rtl/dual_port_ram_sync.sv | 127 ++++++++++++
 tb/tb_dual_port_ram_sync.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_sync.sv
// Synchronous true dual-port RAM with registered reads, write-write collision arbitration
// and a clear sequencer that zero-fills the array after every reset.
module dual_port_ram_sync #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    input  logic              b_en,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid,
    output logic              collision,
    output logic              ready
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              clr_we;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              run;
    logic              a_rd, a_wr, b_rd, b_wr;
    logic              coll;

    logic              wa_en;
    logic [ADDR_W-1:0] wa_addr;
    logic [DATA_W-1:0] wa_data;

    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
    logic              a_rvalid_q, b_rvalid_q, collision_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StClear;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clr_we  = 1'b0;
        case (state_q)
            StClear: begin
                clr_we = 1'b1;
                ptr_d  = ptr_q + ADDR_W'(1);
                if (&ptr_q) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                state_d = StRun;
            end
            default: begin
                state_d = StClear;
            end
        endcase
    end

    assign run  = (state_q == StRun);
    assign a_wr = run & a_en & a_we;
    assign a_rd = run & a_en & ~a_we;
    assign b_wr = run & b_en & b_we;
    assign b_rd = run & b_en & ~b_we;
    assign coll = a_wr & b_wr & (a_addr == b_addr);

    // The clear sequencer borrows port A's write path; requests are gated off while clearing.
    assign wa_en   = clr_we | a_wr;
    assign wa_addr = clr_we ? ptr_q : a_addr;
    assign wa_data = clr_we ? '0 : a_wdata;

    // Array is deliberately not reset; the clear sequence defines its contents.
    always_ff @(posedge clk) begin
        if (b_wr && !coll) begin
            mem[b_addr] <= b_wdata;
        end
        if (wa_en) begin
            mem[wa_addr] <= wa_data;
        end
    end

    // Reads sample the array before this edge's writes land, giving read-first behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            a_rvalid_q  <= a_rd;
            b_rvalid_q  <= b_rd;
            collision_q <= coll;
            if (a_rd) begin
                a_rdata_q <= mem[a_addr];
            end
            if (b_rd) begin
                b_rdata_q <= mem[b_addr];
            end
        end
    end

    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;
    assign collision = collision_q;
    assign ready     = run;

endmodule

// File: tb/tb_dual_port_ram_sync.sv
// Bench for dual_port_ram_sync: two configurations (8x16 and 16x64) share one stimulus stream
// and are checked every cycle against an array-based model, plus literal expectations.
module tb_dual_port_ram_sync;

    localparam int NCFG = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_en = 1'b0, a_we = 1'b0, b_en = 1'b0, b_we = 1'b0;
    logic [5:0]  a_addr = '0, b_addr = '0;
    logic [15:0] a_wdata = '0, b_wdata = '0;

    logic [7:0]  a_rdata0, b_rdata0;
    logic        a_rvalid0, b_rvalid0, col0, rdy0;
    logic [15:0] a_rdata1, b_rdata1;
    logic        a_rvalid1, b_rvalid1, col1, rdy1;

    int nchecks = 0;
    int nerr = 0;

    // Model state, per configuration.
    logic [15:0] m_mem [NCFG][64];
    logic [15:0] e_ard [NCFG];
    logic [15:0] e_brd [NCFG];
    logic        e_arv [NCFG];
    logic        e_brv [NCFG];
    logic        e_col [NCFG];
    logic        e_rdy [NCFG];
    int          edges [NCFG];

    dual_port_ram_sync #(.DATA_W(8), .ADDR_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr[3:0]), .a_wdata(a_wdata[7:0]),
        .a_rdata(a_rdata0), .a_rvalid(a_rvalid0),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr[3:0]), .b_wdata(b_wdata[7:0]),
        .b_rdata(b_rdata0), .b_rvalid(b_rvalid0),
        .collision(col0), .ready(rdy0)
    );

    dual_port_ram_sync #(.DATA_W(16), .ADDR_W(6)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata1), .a_rvalid(a_rvalid1),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata1), .b_rvalid(b_rvalid1),
        .collision(col1), .ready(rdy1)
    );

    always #5 clk = ~clk;

    function automatic int depth(input int c);
        return (c == 0) ? 16 : 64;
    endfunction

    function automatic logic [15:0] dmask(input int c);
        return (c == 0) ? 16'h00FF : 16'hFFFF;
    endfunction

    function automatic int amap(input logic [5:0] a, input int c);
        return int'(a) % depth(c);
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCFG; c++) begin
            e_ard[c] = '0; e_brd[c] = '0;
            e_arv[c] = 1'b0; e_brv[c] = 1'b0; e_col[c] = 1'b0; e_rdy[c] = 1'b0;
            edges[c] = 0;
        end
    endtask

    // One rising edge of the specification: clear counts DEPTH edges, then requests apply.
    task automatic model_edge();
        int   ai, bi;
        logic cl;
        for (int c = 0; c < NCFG; c++) begin
            if (!rst_n) begin
                e_ard[c] = '0; e_brd[c] = '0;
                e_arv[c] = 1'b0; e_brv[c] = 1'b0; e_col[c] = 1'b0; e_rdy[c] = 1'b0;
                edges[c] = 0;
            end else if (edges[c] < depth(c)) begin
                edges[c] = edges[c] + 1;
                e_arv[c] = 1'b0; e_brv[c] = 1'b0; e_col[c] = 1'b0;
                if (edges[c] == depth(c)) begin
                    e_rdy[c] = 1'b1;
                    for (int i = 0; i < 64; i++) m_mem[c][i] = '0;
                end
            end else begin
                ai = amap(a_addr, c);
                bi = amap(b_addr, c);
                e_arv[c] = a_en && !a_we;
                e_brv[c] = b_en && !b_we;
                if (e_arv[c]) e_ard[c] = m_mem[c][ai];
                if (e_brv[c]) e_brd[c] = m_mem[c][bi];
                cl = a_en && a_we && b_en && b_we && (ai == bi);
                e_col[c] = cl;
                if (b_en && b_we && !cl) m_mem[c][bi] = b_wdata & dmask(c);
                if (a_en && a_we) m_mem[c][ai] = a_wdata & dmask(c);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic ae, input logic awe, input logic [5:0] aa,
                         input logic [15:0] ad, input logic be, input logic bwe,
                         input logic [5:0] ba, input logic [15:0] bd);
        a_en = ae; a_we = awe; a_addr = aa; a_wdata = ad;
        b_en = be; b_we = bwe; b_addr = ba; b_wdata = bd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 6'd0, 16'h0, 1'b0, 1'b0, 6'd0, 16'h0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cmp a_rdata0", {8'h00, a_rdata0}, e_ard[0]);
            chk("cmp b_rdata0", {8'h00, b_rdata0}, e_brd[0]);
            chk("cmp a_rvalid0", {15'h0, a_rvalid0}, {15'h0, e_arv[0]});
            chk("cmp b_rvalid0", {15'h0, b_rvalid0}, {15'h0, e_brv[0]});
            chk("cmp collision0", {15'h0, col0}, {15'h0, e_col[0]});
            chk("cmp ready0", {15'h0, rdy0}, {15'h0, e_rdy[0]});
            chk("cmp a_rdata1", a_rdata1, e_ard[1]);
            chk("cmp b_rdata1", b_rdata1, e_brd[1]);
            chk("cmp a_rvalid1", {15'h0, a_rvalid1}, {15'h0, e_arv[1]});
            chk("cmp b_rvalid1", {15'h0, b_rvalid1}, {15'h0, e_brv[1]});
            chk("cmp collision1", {15'h0, col1}, {15'h0, e_col[1]});
            chk("cmp ready1", {15'h0, rdy1}, {15'h0, e_rdy[1]});
        end
    end

    initial begin
        int n;
        model_reset();
        repeat (3) step();
        chk("reset a_rdata0", {8'h00, a_rdata0}, 16'h0000);
        chk("reset a_rvalid0", {15'h0, a_rvalid0}, 16'h0000);
        chk("reset collision0", {15'h0, col0}, 16'h0000);
        chk("reset ready0", {15'h0, rdy0}, 16'h0000);
        chk("reset b_rdata1", b_rdata1, 16'h0000);
        chk("reset ready1", {15'h0, rdy1}, 16'h0000);

        // Release, with requests pending during the clear sequence.
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 6'd2, 16'h00FF, 1'b1, 1'b0, 6'd2, 16'h0);
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("clear ready0", {15'h0, rdy0}, (i == 16) ? 16'h0001 : 16'h0000);
            chk("clear b_rvalid0", {15'h0, b_rvalid0}, 16'h0000);
        end
        idle();
        for (int i = 17; i <= 64; i++) begin
            step();
            chk("clear ready1", {15'h0, rdy1}, (i == 64) ? 16'h0001 : 16'h0000);
        end

        // Every word reads zero after clear, including addr 2 written during clear.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 6'(i), 16'h0, 1'b1, 1'b0, 6'(15 - i), 16'h0);
            step();
            chk("zero a_rdata0", {8'h00, a_rdata0}, 16'h0000);
            chk("zero a_rvalid0", {15'h0, a_rvalid0}, 16'h0001);
            chk("zero b_rdata0", {8'h00, b_rdata0}, 16'h0000);
        end
        idle();
        step();
        chk("rvalid pulse0", {15'h0, a_rvalid0}, 16'h0000);

        // Write on A, read back on B next edge.
        drive(1'b1, 1'b1, 6'd3, 16'h00A5, 1'b0, 1'b0, 6'd0, 16'h0);
        step();
        drive(1'b0, 1'b0, 6'd0, 16'h0, 1'b1, 1'b0, 6'd3, 16'h0);
        step();
        chk("wr-rd b_rdata0", {8'h00, b_rdata0}, 16'h00A5);
        chk("wr-rd b_rvalid0", {15'h0, b_rvalid0}, 16'h0001);

        // Read-first on same address.
        drive(1'b1, 1'b1, 6'd5, 16'h0011, 1'b0, 1'b0, 6'd0, 16'h0);
        step();
        drive(1'b1, 1'b1, 6'd5, 16'h0022, 1'b1, 1'b0, 6'd5, 16'h0);
        step();
        chk("rfirst b_rdata0", {8'h00, b_rdata0}, 16'h0011);
        drive(1'b1, 1'b0, 6'd5, 16'h0, 1'b0, 1'b0, 6'd0, 16'h0);
        step();
        chk("rfirst later a_rdata0", {8'h00, a_rdata0}, 16'h0022);

        // Write-write collision: A wins.
        drive(1'b1, 1'b1, 6'd7, 16'h003C, 1'b1, 1'b1, 6'd7, 16'h00C3);
        step();
        chk("collision0", {15'h0, col0}, 16'h0001);
        chk("collision1", {15'h0, col1}, 16'h0001);
        drive(1'b1, 1'b0, 6'd7, 16'h0, 1'b0, 1'b0, 6'd0, 16'h0);
        step();
        chk("collision pulse0", {15'h0, col0}, 16'h0000);
        chk("collision winner0", {8'h00, a_rdata0}, 16'h003C);
        drive(1'b1, 1'b1, 6'd8, 16'h0081, 1'b1, 1'b1, 6'd9, 16'h0092);
        step();
        chk("no collision0", {15'h0, col0}, 16'h0000);
        drive(1'b1, 1'b0, 6'd8, 16'h0, 1'b1, 1'b0, 6'd9, 16'h0);
        step();
        chk("dual wr a_rdata0", {8'h00, a_rdata0}, 16'h0081);
        chk("dual wr b_rdata0", {8'h00, b_rdata0}, 16'h0092);

        // Randomized traffic with addresses biased towards a small window to force collisions.
        for (int i = 0; i < 600; i++) begin
            a_en = 1'($urandom_range(0, 3) != 0);
            a_we = 1'($urandom_range(0, 1));
            b_en = 1'($urandom_range(0, 3) != 0);
            b_we = 1'($urandom_range(0, 1));
            a_addr = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 63))
                                                 : 6'($urandom_range(0, 3));
            b_addr = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 63))
                                                 : 6'($urandom_range(0, 3));
            a_wdata = 16'($urandom);
            b_wdata = 16'($urandom);
            step();
        end

        // 16-bit round trip on the wide configuration.
        drive(1'b1, 1'b1, 6'd40, 16'hBEEF, 1'b0, 1'b0, 6'd0, 16'h0);
        step();
        drive(1'b0, 1'b0, 6'd0, 16'h0, 1'b1, 1'b0, 6'd40, 16'h0);
        step();
        chk("beef b_rdata1", b_rdata1, 16'hBEEF);
        chk("beef alias b_rdata0", {8'h00, b_rdata0}, 16'h00EF);

        // Reset mid-RUN with a read in flight.
        drive(1'b1, 1'b1, 6'd1, 16'h0077, 1'b0, 1'b0, 6'd0, 16'h0);
        step();
        drive(1'b1, 1'b0, 6'd1, 16'h0, 1'b0, 1'b0, 6'd0, 16'h0);
        step();
        chk("pre-reset a_rdata0", {8'h00, a_rdata0}, 16'h0077);
        chk("pre-reset a_rvalid0", {15'h0, a_rvalid0}, 16'h0001);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async a_rdata0", {8'h00, a_rdata0}, 16'h0000);
        chk("async a_rvalid0", {15'h0, a_rvalid0}, 16'h0000);
        chk("async ready0", {15'h0, rdy0}, 16'h0000);
        chk("async a_rdata1", a_rdata1, 16'h0000);
        chk("async ready1", {15'h0, rdy1}, 16'h0000);
        step();
        rst_n = 1'b1;
        idle();
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("reclear ready0", {15'h0, rdy0}, (i == 16) ? 16'h0001 : 16'h0000);
        end
        drive(1'b1, 1'b0, 6'd1, 16'h0, 1'b0, 1'b0, 6'd0, 16'h0);
        step();
        chk("reclear a_rdata0", {8'h00, a_rdata0}, 16'h0000);
        chk("reclear a_rvalid0", {15'h0, a_rvalid0}, 16'h0001);

        // Reset again while the wide configuration is still clearing.
        idle();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midclear ready0", {15'h0, rdy0}, 16'h0000);
        step();
        rst_n = 1'b1;
        n = 0;
        while (rdy1 !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("clear edges1", 16'(n), 16'd64);
        drive(1'b1, 1'b0, 6'd1, 16'h0, 1'b1, 1'b1, 6'd63, 16'hBEEF);
        step();
        chk("post-clear a_rdata1", a_rdata1, 16'h0000);
        drive(1'b1, 1'b0, 6'd63, 16'h0, 1'b0, 1'b0, 6'd0, 16'h0);
        step();
        chk("beef top a_rdata1", a_rdata1, 16'hBEEF);
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
